// File: rtl/program_counter_unit.sv
// Fetch-address register with branch/return target selection, a circular return-address stack
// and a one-cycle registered redirect pulse for flush logic.
module program_counter_unit #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            OFFSET_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned            RAS_DEPTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branchFlag,
    input  logic                    branchOnNotZero,
    input  logic                    zeroFlag,
    input  logic                    unconditionalBranchFlag,
    input  logic                    linkFlag,
    input  logic                    registerBranchFlag,
    input  logic                    returnFlag,
    input  logic [OFFSET_WIDTH-1:0] pcOffsetFilled,
    input  logic [ADDR_WIDTH-1:0]   registerTarget,
    output logic [ADDR_WIDTH-1:0]   PC,
    output logic [ADDR_WIDTH-1:0]   nextPC,
    output logic [ADDR_WIDTH-1:0]   linkAddress,
    output logic                    branchTaken,
    output logic                    rasEmpty,
    output logic                    rasFull
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  branch_taken_q;
    logic [PtrW-1:0]       top_q, top_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0] off_ext;
    logic [ADDR_WIDTH-1:0] rel_target;
    logic [ADDR_WIDTH-1:0] ret_target;
    logic                  cond_taken;
    logic                  redirect;
    logic                  ras_we;
    logic [PtrW-1:0]       ras_waddr;

    // Offset is sign-extended or truncated to the address width before word scaling.
    if (OFFSET_WIDTH >= ADDR_WIDTH) begin : g_off_trunc
        assign off_ext = pcOffsetFilled[ADDR_WIDTH-1:0];
    end else begin : g_off_sext
        assign off_ext = {{(ADDR_WIDTH - OFFSET_WIDTH){pcOffsetFilled[OFFSET_WIDTH-1]}},
                          pcOffsetFilled};
    end

    assign linkAddress = pc_q + ADDR_WIDTH'(4);
    assign rel_target  = pc_q + (off_ext << 2);
    assign cond_taken  = branchFlag & (zeroFlag ^ branchOnNotZero);
    assign rasEmpty    = (count_q == '0);
    assign rasFull     = (count_q == CntW'(RAS_DEPTH));
    assign ret_target  = rasEmpty ? registerTarget : ras_q[top_q];
    assign redirect    = returnFlag | registerBranchFlag | unconditionalBranchFlag | cond_taken;
    assign PC          = pc_q;
    assign branchTaken = branch_taken_q;

    always_comb begin
        nextPC = linkAddress;
        if (returnFlag) begin
            nextPC = ret_target;
        end else if (registerBranchFlag) begin
            nextPC = registerTarget;
        end else if (unconditionalBranchFlag || cond_taken) begin
            nextPC = rel_target;
        end
    end

    always_comb begin
        top_d     = top_q;
        count_d   = count_q;
        ras_we    = 1'b0;
        ras_waddr = top_q;
        if (linkFlag && !returnFlag) begin
            // When full, advancing the pointer overwrites the oldest entry.
            ras_we    = 1'b1;
            ras_waddr = top_q + 1'b1;
            top_d     = top_q + 1'b1;
            if (!rasFull) begin
                count_d = count_q + 1'b1;
            end
        end else if (returnFlag && !linkFlag) begin
            if (!rasEmpty) begin
                top_d   = top_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end else if (returnFlag && linkFlag) begin
            ras_we = 1'b1;
            if (rasEmpty) begin
                count_d = CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q           <= RESET_VECTOR;
            branch_taken_q <= 1'b0;
            top_q          <= '0;
            count_q        <= '0;
        end else if (stall) begin
            branch_taken_q <= 1'b0;
        end else begin
            pc_q           <= nextPC;
            branch_taken_q <= redirect;
            top_q          <= top_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !stall && ras_we) begin
            ras_q[ras_waddr] <= linkAddress;
        end
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Parametrised next-generation PC block for the ARM-LP core. It holds the fetch address in a real register and selects among sequential, PC-relative conditional (CBZ/CBNZ), unconditional (B/BL), register (BR) and return targets. It adds a stall/hold, a return-address stack (RAS) for BL/RET, and a registered redirect pulse for downstream flush logic. It sits between decode/ALU flags and instruction memory.

Parameters:
ADDR_WIDTH, 32, width of PC and all target addresses
OFFSET_WIDTH, 32, width of sign-extended branch offset input
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
stall  input  1  1 = hold all state this cycle
branchFlag  input  1  conditional branch (CBZ/CBNZ) decoded
branchOnNotZero  input  1  1 = CBNZ sense, 0 = CBZ sense
zeroFlag  input  1  ALU zero result
unconditionalBranchFlag  input  1  B/BL decoded
linkFlag  input  1  BL: push return address
registerBranchFlag  input  1  BR: jump to registerTarget
returnFlag  input  1  RET: pop RAS for target
pcOffsetFilled  input  OFFSET_WIDTH  sign-extended word offset
registerTarget  input  ADDR_WIDTH  register value for BR / RAS-empty RET
PC  output  ADDR_WIDTH  current fetch address (registered)
nextPC  output  ADDR_WIDTH  combinational next address
linkAddress  output  ADDR_WIDTH  PC + 4, for X30 writeback
branchTaken  output  1  registered pulse: previous cycle redirected
rasEmpty  output  1  RAS count == 0
rasFull  output  1  RAS count == RAS_DEPTH

Behaviour:
- Clock port is clock; reset is synchronous, active-high. On reset: PC=RESET_VECTOR, branchTaken=0, RAS count=0 (rasEmpty=1, rasFull=0); RAS contents don't-care. Reset wins over stall and all flags.
- Control inputs describe the instruction at the current PC.
- Offset scaling: target = PC + (sign-extend(pcOffsetFilled) << 2), modulo 2^ADDR_WIDTH; offset sign-extended/truncated to ADDR_WIDTH before shifting.
- condTaken = branchFlag & (zeroFlag ^ branchOnNotZero).
- nextPC priority: returnFlag (RAS top, or registerTarget if empty) > registerBranchFlag (registerTarget) > unconditionalBranchFlag (offset target) > condTaken (offset target) > PC+4. All wrap modulo 2^ADDR_WIDTH.
- redirect = any non-sequential selection above.
- Posedge, not reset: stall=1 -> PC, RAS, count unchanged, branchTaken<=0. stall=0 -> PC<=nextPC, branchTaken<=redirect.
- Latency: new PC visible one cycle after the deciding cycle; branchTaken high exactly that following cycle, one cycle per redirect.
- RAS (circular, top pointer + count), updated only when stall=0:
  push (linkFlag & ~returnFlag): write linkAddress at top+1; count saturates at RAS_DEPTH; when full, oldest entry overwritten.
  pop (returnFlag & ~linkFlag): count>0 -> target=top, count-1; count==0 -> use registerTarget, count stays 0, no pointer move.
  both: target=old top (registerTarget if empty); top entry replaced by linkAddress; count unchanged (0 -> 1 if empty).
- linkFlag without unconditionalBranchFlag still pushes (decode guarantees it never occurs).
- PC bits [1:0] are not forced; a misaligned registerTarget propagates unchanged.

Test Plan:
- Reset with RESET_VECTOR=0x100, then 3 idle cycles -> PC 0x100, 0x104, 0x108, 0x10C; branchTaken=0 throughout.
- PC=0x200, branchFlag=1, zeroFlag=1, branchOnNotZero=0, pcOffsetFilled=-4 -> next PC 0x1F0, branchTaken=1 one cycle; repeat with branchOnNotZero=1 -> PC 0x204, branchTaken=0.
- stall=1 for 3 cycles while unconditionalBranchFlag=1 -> PC and RAS frozen, branchTaken=0; release -> branch taken next cycle.
- BL at 0x1000 (offset 0x40) -> PC 0x1100, RAS holds 0x1004; RET -> PC 0x1004, rasEmpty=1; RET again with registerTarget=0x3000 -> PC 0x3000, count stays 0.
- RAS_DEPTH=4: 5 nested BLs pushing A..E -> rasFull=1; 4 RETs return E,D,C,B; 5th RET uses registerTarget.
- Wrap: PC=0xFFFFFFFC sequential -> 0x00000000; reset asserted mid-branch with stall=1 -> PC=RESET_VECTOR, rasEmpty=1 next cycle.
